// File: rtl/pin_bus_arbiter.sv
// Round-robin arbiter that shares one pin_if slave bus among NUM_REQ masters.
// One transaction runs at a time; a per-transaction timeout frees the bus from a dead slave.
module pin_bus_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int DW         = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            r_req,
  input  logic [NUM_REQ-1:0]            r_rw,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] r_address,
  input  logic [NUM_REQ*DW-1:0]         r_wr_data,
  output logic [NUM_REQ-1:0]            r_ack,
  output logic [NUM_REQ-1:0]            r_err,
  output logic [DW-1:0]                 r_rd_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic [ADDR_WIDTH-1:0]         m_address,
  output logic [DW-1:0]                 m_wr_data,
  output logic                          m_rw,
  output logic                          m_req,
  input  logic [DW-1:0]                 m_rd_data,
  input  logic                          m_ack,
  input  logic                          m_err
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e                 state_q, state_d;
  logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]          gidx_q, gidx_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [NUM_REQ-1:0]     r_ack_q, r_ack_d;
  logic [NUM_REQ-1:0]     r_err_q, r_err_d;
  logic [DW-1:0]          r_rd_data_q, r_rd_data_d;
  logic [ADDR_WIDTH-1:0]  m_address_q, m_address_d;
  logic [DW-1:0]          m_wr_data_q, m_wr_data_d;
  logic                   m_rw_q, m_rw_d;
  logic                   m_req_q, m_req_d;
  logic [IW-1:0]          pick_idx;

  // First set request bit at or above ptr, wrapping modulo NUM_REQ.
  function automatic logic [IW-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                            input logic [IW-1:0]      ptr);
    logic [IW-1:0] sel;
    logic          found;
    int            idx;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx[IW-1:0]]) begin
        found = 1'b1;
        sel   = idx[IW-1:0];
      end
    end
    return sel;
  endfunction

  assign pick_idx = rr_pick(r_req, rr_ptr_q);

  always_comb begin
    // NOTE: every _d takes its hold value first, so no branch can leave a latch behind.
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gidx_d      = gidx_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    r_ack_d     = '0;
    r_err_d     = '0;
    r_rd_data_d = r_rd_data_q;
    m_address_d = m_address_q;
    m_wr_data_d = m_wr_data_q;
    m_rw_d      = m_rw_q;
    m_req_d     = m_req_q;

    case (state_q)
      IDLE: begin
        if (|r_req) begin
          gidx_d      = pick_idx;
          grant_d     = NUM_REQ'(1) << pick_idx;
          m_address_d = r_address[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          m_wr_data_d = r_wr_data[int'(pick_idx)*DW +: DW];
          m_rw_d      = r_rw[pick_idx];
          m_req_d     = 1'b1;
          cnt_d       = '0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        // Error outranks a simultaneous ack, and leaves read data untouched.
        if (m_err) begin
          r_err_d[gidx_q] = 1'b1;
          m_req_d         = 1'b0;
          state_d         = RESP;
        end else if (m_ack) begin
          r_rd_data_d     = m_rd_data;
          r_ack_d[gidx_q] = 1'b1;
          m_req_d         = 1'b0;
          state_d         = RESP;
        end else if (TIMEOUT != 0 && cnt_q == CW'(TIMEOUT - 1)) begin
          r_err_d[gidx_q] = 1'b1;
          m_req_d         = 1'b0;
          state_d         = RESP;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        rr_ptr_d = (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
        grant_d  = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      gidx_q      <= '0;
      cnt_q       <= '0;
      grant_q     <= '0;
      r_ack_q     <= '0;
      r_err_q     <= '0;
      r_rd_data_q <= '0;
      m_address_q <= '0;
      m_wr_data_q <= '0;
      m_rw_q      <= 1'b0;
      m_req_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gidx_q      <= gidx_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      r_ack_q     <= r_ack_d;
      r_err_q     <= r_err_d;
      r_rd_data_q <= r_rd_data_d;
      m_address_q <= m_address_d;
      m_wr_data_q <= m_wr_data_d;
      m_rw_q      <= m_rw_d;
      m_req_q     <= m_req_d;
    end
  end

  assign r_ack     = r_ack_q;
  assign r_err     = r_err_q;
  assign r_rd_data = r_rd_data_q;
  assign grant     = grant_q;
  assign m_address = m_address_q;
  assign m_wr_data = m_wr_data_q;
  assign m_rw      = m_rw_q;
  assign m_req     = m_req_q;

endmodule
